pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_pkg.sv | 19 +
 rtl/pattern_sequencer_vsync_edge_det.sv | 22 ++
 rtl/pattern_sequencer.sv | 113 +++++++++++
 tb/tb_pattern_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared encodings for the test-pattern sequencer: FSM states, ASCII command bytes
// and the default pattern count.
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL  = 2'd0,
        ST_PENDING = 2'd1,
        ST_AUTO    = 2'd2
    } state_t;

    localparam int NUM_PATTERNS_DEFAULT = 7;

    localparam logic [7:0] CMD_ZERO    = 8'h30;
    localparam logic [7:0] CMD_AUTO_UC = 8'h41;
    localparam logic [7:0] CMD_AUTO_LC = 8'h61;
    localparam logic [7:0] CMD_STOP_UC = 8'h53;
    localparam logic [7:0] CMD_STOP_LC = 8'h73;

endpackage

// File: rtl/pattern_sequencer_vsync_edge_det.sv
// Registers i_VSync and flags the first low cycle after an active-row period
// (the vblank cycle). Reset clears the history so no edge appears right after reset.
module vsync_edge_det (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_VSync,
    output logic o_VBlank
);

    logic r_VSync;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_VSync <= 1'b0;
        end else begin
            r_VSync <= i_VSync;
        end
    end

    assign o_VBlank = r_VSync & ~i_VSync;

endmodule

// File: rtl/pattern_sequencer.sv
// Selects the pattern shown by the pattern generator from UART command bytes, either
// manually (digit applied at the next vblank) or by auto-cycling every few frames.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS       = NUM_PATTERNS_DEFAULT,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_VSync,
    output logic [3:0] o_Pattern,
    output logic       o_Auto,
    output logic       o_Pending,
    output logic       o_Frame_Tick,
    output logic       o_Cmd_Err
);

    // Handshake: i_Rx_DV is a one-cycle valid strobe with no ready/backpressure;
    // every cycle with i_Rx_DV=1 consumes i_Rx_Byte in that same cycle.

    localparam logic [7:0] DIGIT_LAST = 8'(32'(CMD_ZERO) + NUM_PATTERNS - 1);
    localparam logic [7:0] CNT_LAST   = 8'(FRAMES_PER_PATTERN - 1);
    localparam logic [3:0] PAT_LAST   = 4'(NUM_PATTERNS - 1);

    state_t     r_State, w_Next_State;
    logic [3:0] r_Pending, w_Next_Pending;
    logic [7:0] r_Frame_Cnt, w_Next_Cnt;
    logic [3:0] w_Next_Pattern;
    logic       w_Cmd_Err;
    logic       w_VBlank;
    logic       w_Is_Digit, w_Is_Auto, w_Is_Stop;

    vsync_edge_det u_vsync_edge_det (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_VSync  (i_VSync),
        .o_VBlank (w_VBlank)
    );

    assign w_Is_Digit = (i_Rx_Byte >= CMD_ZERO) && (i_Rx_Byte <= DIGIT_LAST);
    assign w_Is_Auto  = (i_Rx_Byte == CMD_AUTO_UC) || (i_Rx_Byte == CMD_AUTO_LC);
    assign w_Is_Stop  = (i_Rx_Byte == CMD_STOP_UC) || (i_Rx_Byte == CMD_STOP_LC);

    always_comb begin
        w_Next_State   = r_State;
        w_Next_Pending = r_Pending;
        w_Next_Pattern = o_Pattern;
        w_Next_Cnt     = r_Frame_Cnt;
        w_Cmd_Err      = 1'b0;

        // Vblank effects use the state held before this cycle's command.
        if (w_VBlank) begin
            case (r_State)
                ST_PENDING: begin
                    w_Next_Pattern = r_Pending;
                    w_Next_State   = ST_MANUAL;
                end
                ST_AUTO: begin
                    if (r_Frame_Cnt == CNT_LAST) begin
                        w_Next_Cnt     = 8'd0;
                        w_Next_Pattern = (o_Pattern >= PAT_LAST) ? 4'd1 : o_Pattern + 4'd1;
                    end else begin
                        w_Next_Cnt = r_Frame_Cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        if (i_Rx_DV) begin
            if (w_Is_Digit) begin
                // Digits are 0x30..0x39, so the low nibble is the pattern code.
                w_Next_Pending = i_Rx_Byte[3:0];
                w_Next_State   = ST_PENDING;
            end else if (w_Is_Auto) begin
                w_Next_State   = ST_AUTO;
                w_Next_Cnt     = 8'd0;
                w_Next_Pattern = o_Pattern;
            end else if (w_Is_Stop) begin
                // Stop cancels a same-cycle advance or pending apply.
                w_Next_State   = ST_MANUAL;
                w_Next_Pattern = o_Pattern;
            end else begin
                w_Cmd_Err = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State      <= ST_MANUAL;
            r_Pending    <= 4'd0;
            r_Frame_Cnt  <= 8'd0;
            o_Pattern    <= 4'd0;
            o_Frame_Tick <= 1'b0;
            o_Cmd_Err    <= 1'b0;
        end else begin
            r_State      <= w_Next_State;
            r_Pending    <= w_Next_Pending;
            r_Frame_Cnt  <= w_Next_Cnt;
            o_Pattern    <= w_Next_Pattern;
            o_Frame_Tick <= w_VBlank;
            o_Cmd_Err    <= w_Cmd_Err;
        end
    end

    assign o_Auto    = (r_State == ST_AUTO);
    assign o_Pending = (r_State == ST_PENDING);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random command traffic,
// every cycle compared against a frame-level reference model through an expected queue.
module tb_pattern_sequencer;

    localparam int NP  = 7;
    localparam int FPP = 3;

    localparam int MODE_MANUAL  = 0;
    localparam int MODE_PENDING = 1;
    localparam int MODE_AUTO    = 2;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'd0;
    logic       i_VSync = 1'b0;
    logic [3:0] o_Pattern;
    logic       o_Auto, o_Pending, o_Frame_Tick, o_Cmd_Err;

    int checks = 0;
    int errors = 0;
    int tick_acc = 0;
    int err_acc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] s_obs;
    logic [3:0] frame_pat  [25];
    logic       frame_auto [25];
    logic       frame_pend [25];

    // reference model: what the viewer should see, by the command rules
    int m_mode, m_pend, m_pat, m_frames;
    logic m_prev_vs;

    pattern_sequencer #(.NUM_PATTERNS(NP), .FRAMES_PER_PATTERN(FPP)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .i_VSync      (i_VSync),
        .o_Pattern    (o_Pattern),
        .o_Auto       (o_Auto),
        .o_Pending    (o_Pending),
        .o_Frame_Tick (o_Frame_Tick),
        .o_Cmd_Err    (o_Cmd_Err)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [7:0] model_step(input logic rst, input logic vs,
                                              input logic dv, input logic [7:0] b);
        logic vb, is_digit, is_a, is_s, bad;
        if (rst) begin
            m_mode = MODE_MANUAL; m_pend = 0; m_pat = 0; m_frames = 0; m_prev_vs = 1'b0;
            return 8'd0;
        end
        vb = m_prev_vs && !vs;
        m_prev_vs = vs;
        is_digit = dv && (int'(b) >= 'h30) && (int'(b) < 'h30 + NP);
        is_a = dv && (b == 8'h41 || b == 8'h61);
        is_s = dv && (b == 8'h53 || b == 8'h73);
        bad = dv && !is_digit && !is_a && !is_s;
        if (vb && !is_a && !is_s) begin
            if (m_mode == MODE_PENDING) begin
                m_pat = m_pend;
                m_mode = MODE_MANUAL;
            end else if (m_mode == MODE_AUTO) begin
                m_frames++;
                if (m_frames == FPP) begin
                    m_frames = 0;
                    m_pat = m_pat % (NP - 1) + 1;
                end
            end
        end
        if (is_digit) begin
            m_pend = int'(b) - 'h30;
            m_mode = MODE_PENDING;
        end else if (is_a) begin
            m_mode = MODE_AUTO;
            m_frames = 0;
        end else if (is_s) begin
            m_mode = MODE_MANUAL;
        end
        return {4'(m_pat), m_mode == MODE_AUTO, m_mode == MODE_PENDING, vb, bad};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cycle(input logic rst, input logic vs, input logic dv, input logic [7:0] b);
        logic [7:0] exp_w;
        @(negedge i_Clk);
        s_obs = {o_Pattern, o_Auto, o_Pending, o_Frame_Tick, o_Cmd_Err};
        if (s_obs[1] === 1'b1) tick_acc++;
        if (s_obs[0] === 1'b1) err_acc++;
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            assert (s_obs === exp_w) else begin
                errors++;
                $error("FAIL scoreboard at %0t: observed %h expected %h", $time, s_obs, exp_w);
            end
        end
        i_Reset   = rst;
        i_VSync   = vs;
        i_Rx_DV   = dv;
        i_Rx_Byte = dv ? b : 8'd0;
        exp_q.push_back(model_step(rst, vs, dv, b));
    endtask

    // one frame: 20 active cycles then 5 blanking cycles; index 20 is the vblank cycle
    task automatic run_frame(input int c1, input logic [7:0] b1, input int c2,
                             input logic [7:0] b2, input int rst_at);
        for (int i = 0; i < 25; i++) begin
            cycle(i == rst_at, i < 20, (i == c1) || (i == c2), (i == c1) ? b1 : b2);
            frame_pat[i]  = s_obs[7:4];
            frame_auto[i] = s_obs[3];
            frame_pend[i] = s_obs[2];
        end
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5) return 8'(8'h30 + $urandom_range(0, 7));
        if (r == 5) return 8'h41;
        if (r == 6) return 8'h61;
        if (r == 7) return ($urandom_range(0, 1) == 0) ? 8'h53 : 8'h73;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset_pattern", 8'(s_obs[7:4]), 8'd0);
        chk("reset_auto", 8'(s_obs[3]), 8'd0);
        chk("reset_pending", 8'(s_obs[2]), 8'd0);

        tick_acc = 0; err_acc = 0;
        for (int f = 0; f < 10; f++) run_frame(-1, 8'd0, -1, 8'd0, -1);
        chk("idle_ticks", 8'(tick_acc), 8'd10);
        chk("idle_errs", 8'(err_acc), 8'd0);
        chk("idle_pattern", 8'(frame_pat[24]), 8'd0);

        run_frame(3, 8'h32, 8, 8'h34, -1);
        chk("overwrite_pend_before", 8'(frame_pend[19]), 8'd1);
        chk("overwrite_applied", 8'(frame_pat[21]), 8'd4);

        run_frame(5, 8'h35, -1, 8'd0, -1);
        chk("digit_pending", 8'(frame_pend[6]), 8'd1);
        chk("digit_before_vb", 8'(frame_pat[20]), 8'd4);
        chk("digit_after_vb", 8'(frame_pat[21]), 8'd5);
        chk("digit_pend_clear", 8'(frame_pend[21]), 8'd0);

        run_frame(5, 8'h41, -1, 8'd0, -1);
        chk("auto_enter", 8'(frame_auto[6]), 8'd1);
        chk("auto_hold", 8'(frame_pat[24]), 8'd5);
        run_frame(-1, 8'd0, -1, 8'd0, -1);
        run_frame(-1, 8'd0, -1, 8'd0, -1);
        chk("auto_3_vblanks", 8'(frame_pat[21]), 8'd6);
        for (int f = 0; f < 3; f++) run_frame(-1, 8'd0, -1, 8'd0, -1);
        chk("auto_wrap_before", 8'(frame_pat[20]), 8'd6);
        chk("auto_wrap", 8'(frame_pat[21]), 8'd1);

        run_frame(5, 8'h53, -1, 8'd0, -1);
        chk("stop_auto_off", 8'(frame_auto[6]), 8'd0);
        run_frame(-1, 8'd0, -1, 8'd0, -1);
        chk("stop_frozen", 8'(frame_pat[24]), 8'd1);

        err_acc = 0;
        run_frame(3, 8'h37, 10, 8'h5A, -1);
        chk("bad_cmd_pulses", 8'(err_acc), 8'd2);
        chk("bad_cmd_pattern", 8'(frame_pat[24]), 8'd1);
        chk("bad_cmd_pending", 8'(frame_pend[24]), 8'd0);

        run_frame(20, 8'h33, -1, 8'd0, -1);
        chk("vb_digit_not_now", 8'(frame_pat[21]), 8'd1);
        chk("vb_digit_pending", 8'(frame_pend[21]), 8'd1);
        run_frame(-1, 8'd0, -1, 8'd0, -1);
        chk("vb_digit_next", 8'(frame_pat[21]), 8'd3);

        run_frame(5, 8'h36, -1, 8'd0, 10);
        chk("rst_pend_before", 8'(frame_pend[6]), 8'd1);
        chk("rst_pend_cleared", 8'(frame_pend[11]), 8'd0);
        chk("rst_pend_no_apply", 8'(frame_pat[21]), 8'd0);

        tick_acc = 0;
        run_frame(5, 8'h32, -1, 8'd0, 19);
        chk("rst_no_false_vblank", 8'(tick_acc), 8'd0);
        chk("rst_late_pattern", 8'(frame_pat[21]), 8'd0);

        run_frame(2, 8'h61, -1, 8'd0, 10);
        chk("rst_auto_before", 8'(frame_auto[3]), 8'd1);
        chk("rst_auto_cleared", 8'(frame_auto[11]), 8'd0);
        for (int f = 0; f < 3; f++) run_frame(-1, 8'd0, -1, 8'd0, -1);
        chk("rst_auto_no_advance", 8'(frame_pat[24]), 8'd0);

        for (int f = 0; f < 40; f++) begin
            int c1, c2, ra;
            logic [7:0] b1, b2;
            c1 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 24));
            c2 = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 24));
            ra = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 24)) : -1;
            b1 = pick_byte();
            b2 = pick_byte();
            run_frame(c1, b1, c2, b2, ra);
        end

        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
